// File: rtl/ifetch_queue_if.sv
// Instruction-memory fetch port between ifetch_queue (master) and the memory (slave).
interface ifetch_queue_if #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int FETCH_W = 2
);
    logic                      mem_req;
    logic [ADDR_W-1:0]         mem_addr;
    logic                      mem_gnt;
    logic                      mem_rvalid;
    logic [FETCH_W*DATA_W-1:0] mem_rdata;

    modport master (output mem_req, mem_addr, input mem_gnt, mem_rvalid, mem_rdata);
    modport slave  (input mem_req, mem_addr, output mem_gnt, mem_rvalid, mem_rdata);
endinterface

// File: rtl/ifetch_queue.sv
// Instruction prefetch ring feeding the dual-issue scheduler with its two oldest entries.
// Define IFQ_BYPASS_EN to forward a response straight to the outputs when the queue is empty.
module ifetch_queue #(
    parameter int                DATA_W   = 32,
    parameter int                ADDR_W   = 32,
    parameter int                DEPTH    = 8,
    parameter int                FETCH_W  = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              n_rst,
    ifetch_queue_if.master    mem,
    input  logic [1:0]        consume,
    input  logic              redirect,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic [DATA_W-1:0] instr0,
    output logic [DATA_W-1:0] instr1,
    output logic              valid0,
    output logic              valid1,
    output logic [ADDR_W-1:0] pc0,
    output logic              empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int W1    = (FETCH_W > 1) ? 1 : 0;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] FETCH_C = CNT_W'(FETCH_W);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DROP} state_t;

    state_t                      state, state_nx;
    logic [DATA_W-1:0]           ring_data [DEPTH];
    logic [ADDR_W-1:0]           ring_pc   [DEPTH];
    logic [PTR_W-1:0]            head, tail;
    logic [CNT_W-1:0]            count, count_nx, avail, creq, retired, written;
    logic [ADDR_W-1:0]           fetch_pc;
    logic                        accept, byp;
    logic [FETCH_W-1:0][DATA_W-1:0] words;
    logic                        unused_pc_lsb;

    assign unused_pc_lsb = &{1'b0, redirect_pc[1:0]};
    assign words  = mem.mem_rdata;
    assign accept = (state == S_WAIT) && mem.mem_rvalid && !redirect;
`ifdef IFQ_BYPASS_EN
    assign byp = accept && (count == '0);
`else
    assign byp = 1'b0;
`endif

    // Bypassed words are retirable in the cycle they arrive; otherwise only stored entries are.
    assign avail    = byp ? FETCH_C : count;
    assign creq     = (consume == 2'd3) ? CNT_W'(2) : CNT_W'(consume);
    assign retired  = redirect ? '0 : ((creq < avail) ? creq : avail);
    assign written  = accept ? FETCH_C : '0;
    assign count_nx = redirect ? '0 : count + written - retired;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) state <= S_IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            S_IDLE: if (redirect || (DEPTH_C - count >= FETCH_C)) state_nx = S_REQ;
            S_REQ: begin
                if (mem.mem_gnt) state_nx = redirect ? S_DROP : S_WAIT;
            end
            S_WAIT: begin
                if (redirect)
                    state_nx = mem.mem_rvalid ? S_REQ : S_DROP;
                else if (mem.mem_rvalid)
                    state_nx = (DEPTH_C - count_nx >= FETCH_C) ? S_REQ : S_IDLE;
            end
            S_DROP: if (redirect || mem.mem_rvalid) state_nx = S_REQ;
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            fetch_pc <= RESET_PC;
        end else begin
            count <= count_nx;
            if (redirect) begin
                head     <= tail;
                fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
            end else begin
                head <= head + retired[PTR_W-1:0];
                if (accept) begin
                    tail     <= tail + PTR_W'(FETCH_W);
                    fetch_pc <= fetch_pc + ADDR_W'(4 * FETCH_W);
                end
            end
        end
    end

    // Ring contents need no reset: outputs are gated by count.
    always_ff @(posedge clk) begin
        if (accept) begin
            for (int k = 0; k < FETCH_W; k++) begin
                ring_data[tail + PTR_W'(k)] <= words[k];
                ring_pc[tail + PTR_W'(k)]   <= fetch_pc + ADDR_W'(4 * k);
            end
        end
    end

    always_comb begin
        mem.mem_req  = (state == S_REQ);
        mem.mem_addr = fetch_pc;
        valid0 = (count != '0);
        valid1 = (count > CNT_W'(1));
        instr0 = valid0 ? ring_data[head] : '0;
        instr1 = valid1 ? ring_data[head + PTR_W'(1)] : '0;
        pc0    = valid0 ? ring_pc[head] : '0;
        if (byp) begin
            valid0 = 1'b1;
            valid1 = (FETCH_W > 1);
            instr0 = words[0];
            instr1 = (FETCH_W > 1) ? words[W1] : '0;
            pc0    = fetch_pc;
        end
        empty = (count == '0);
    end

`ifndef SYNTHESIS
    rsp_outside_wait: assert property (@(posedge clk) disable iff (!n_rst)
        mem.mem_rvalid |-> (state == S_WAIT || state == S_DROP));
`endif
endmodule

// File: tb/tb_ifetch_queue.sv
// Directed bench for ifetch_queue: DEPTH=8, FETCH_W=2, with a 1-cycle memory model for streaming phases.
module tb_ifetch_queue;
    localparam int DATA_W = 32, ADDR_W = 32, DEPTH = 8, FETCH_W = 2;

    logic clk = 1'b0;
    logic n_rst;
    logic [1:0] consume;
    logic redirect;
    logic [ADDR_W-1:0] redirect_pc;
    logic [DATA_W-1:0] instr0, instr1;
    logic valid0, valid1, empty;
    logic [ADDR_W-1:0] pc0;

    int n_chk = 0, n_err = 0;
    int seen;
    logic [31:0] exp_pc;
    logic pend;
    logic [ADDR_W-1:0] pend_a;

    ifetch_queue_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .FETCH_W(FETCH_W)) mem_if ();

    ifetch_queue #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .FETCH_W(FETCH_W), .RESET_PC('0)
    ) dut (
        .clk(clk), .n_rst(n_rst), .mem(mem_if),
        .consume(consume), .redirect(redirect), .redirect_pc(redirect_pc),
        .instr0(instr0), .instr1(instr1), .valid0(valid0), .valid1(valid1),
        .pc0(pc0), .empty(empty)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return 32'hC000_0000 | a;
    endfunction

    // Grant every request, answer one cycle after the grant; optionally track the pc0 stream.
    task automatic run_mem(input int n, input logic [1:0] cons, input bit seq);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            consume           = cons;
            mem_if.mem_rvalid = pend;
            mem_if.mem_rdata  = {word(pend_a + 32'd4), word(pend_a)};
            mem_if.mem_gnt    = mem_if.mem_req;
            pend   = mem_if.mem_req;
            pend_a = mem_if.mem_addr;
            #1;
            if (seq && valid0) begin
                chk("seq_pc0", pc0, exp_pc);
                chk("seq_i0", instr0, word(exp_pc));
                chk("seq_i1", instr1, word(exp_pc + 32'd4));
                chk("seq_v1", valid1, 1'b1);
                exp_pc += 32'd8;
                seen++;
            end
        end
        @(negedge clk);
        consume = 2'd0;
        mem_if.mem_gnt = 1'b0;
        mem_if.mem_rvalid = 1'b0;
        pend = 1'b0;
    endtask

    initial begin
        n_rst = 1'b1; consume = 2'd0; redirect = 1'b0; redirect_pc = '0;
        mem_if.mem_gnt = 1'b0; mem_if.mem_rvalid = 1'b0; mem_if.mem_rdata = '0;
        pend = 1'b0; pend_a = '0; seen = 0; exp_pc = '0;
        #1 n_rst = 1'b0;
        #2;
        chk("rst_req", mem_if.mem_req, 1'b0);
        chk("rst_addr", mem_if.mem_addr, 32'h0);
        chk("rst_v0", valid0, 1'b0);
        chk("rst_v1", valid1, 1'b0);
        chk("rst_i0", instr0, 32'h0);
        chk("rst_i1", instr1, 32'h0);
        chk("rst_pc0", pc0, 32'h0);
        chk("rst_empty", empty, 1'b1);

        // first fetch: grant immediately, respond three cycles later
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        chk("first_req", mem_if.mem_req, 1'b1);
        chk("first_addr", mem_if.mem_addr, 32'h0);
        mem_if.mem_gnt = 1'b1;
        @(negedge clk); mem_if.mem_gnt = 1'b0;
        chk("wait_req", mem_if.mem_req, 1'b0);
        @(negedge clk);
        @(negedge clk);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = {32'h0020_0093, 32'h0010_0013};
        #1;
`ifdef IFQ_BYPASS_EN
        chk("byp_v0", valid0, 1'b1);
        chk("byp_i0", instr0, 32'h0010_0013);
        chk("byp_i1", instr1, 32'h0020_0093);
        chk("byp_pc0", pc0, 32'h0);
`else
        chk("lat_v0", valid0, 1'b0);
`endif
        @(negedge clk); mem_if.mem_rvalid = 1'b0;
        chk("f1_i0", instr0, 32'h0010_0013);
        chk("f1_i1", instr1, 32'h0020_0093);
        chk("f1_pc0", pc0, 32'h0);
        chk("f1_v0", valid0, 1'b1);
        chk("f1_v1", valid1, 1'b1);
        chk("f1_empty", empty, 1'b0);
        chk("f1_req", mem_if.mem_req, 1'b1);
        chk("f1_addr", mem_if.mem_addr, 32'h8);

        // consume one while granted, then consume one as the response lands with count=1
        mem_if.mem_gnt = 1'b1; consume = 2'd1;
        @(negedge clk); mem_if.mem_gnt = 1'b0; consume = 2'd0;
        chk("c1_pc0", pc0, 32'h4);
        chk("c1_i0", instr0, 32'h0020_0093);
        chk("c1_v1", valid1, 1'b0);
        chk("c1_req", mem_if.mem_req, 1'b0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = {32'h2222_2222, 32'h1111_1111};
        consume = 2'd1;
        @(negedge clk); mem_if.mem_rvalid = 1'b0; consume = 2'd0;
        chk("wc_pc0", pc0, 32'h8);
        chk("wc_i0", instr0, 32'h1111_1111);
        chk("wc_i1", instr1, 32'h2222_2222);
        chk("wc_v1", valid1, 1'b1);
        chk("wc_req", mem_if.mem_req, 1'b1);
        chk("wc_addr", mem_if.mem_addr, 32'h10);

        // redirect while waiting for a response
        mem_if.mem_gnt = 1'b1;
        @(negedge clk); mem_if.mem_gnt = 1'b0;
        redirect = 1'b1; redirect_pc = 32'h103;
        @(negedge clk); redirect = 1'b0;
        chk("rd_v0", valid0, 1'b0);
        chk("rd_empty", empty, 1'b1);
        chk("rd_req", mem_if.mem_req, 1'b0);
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = {32'hDEAD_BEEF, 32'hDEAD_BEEF};
        @(negedge clk); mem_if.mem_rvalid = 1'b0;
        chk("drop_v0", valid0, 1'b0);
        chk("drop_req", mem_if.mem_req, 1'b1);
        chk("drop_addr", mem_if.mem_addr, 32'h100);
        mem_if.mem_gnt = 1'b1;
        @(negedge clk); mem_if.mem_gnt = 1'b0;
        mem_if.mem_rvalid = 1'b1;
        mem_if.mem_rdata  = {32'hAAAA_0104, 32'hAAAA_0100};
        @(negedge clk); mem_if.mem_rvalid = 1'b0;
        chk("nw_pc0", pc0, 32'h100);
        chk("nw_i0", instr0, 32'hAAAA_0100);
        chk("nw_i1", instr1, 32'hAAAA_0104);
        chk("nw_addr", mem_if.mem_addr, 32'h108);

        // fill with no consumption: must stop at DEPTH and rest with no request
        run_mem(30, 2'd0, 1'b0);
        chk("full_req", mem_if.mem_req, 1'b0);
        chk("full_pc0", pc0, 32'h100);
        chk("full_v1", valid1, 1'b1);
        repeat (3) @(negedge clk);
        chk("full_hold_req", mem_if.mem_req, 1'b0);

        // drain exactly four pairs: proves count was 8
        for (int i = 0; i < 4; i++) begin
            chk("drain_pc0", pc0, 32'h100 + 32'(8 * i));
            chk("drain_i0", instr0, (i == 0) ? 32'hAAAA_0100 : word(32'h100 + 32'(8 * i)));
            consume = 2'd2;
            @(negedge clk);
        end
        consume = 2'd0;
        chk("drain_empty", empty, 1'b1);
        chk("drain_v0", valid0, 1'b0);
        chk("drain_req", mem_if.mem_req, 1'b1);
        chk("drain_addr", mem_if.mem_addr, 32'h120);

        // over-consume on an empty queue is clamped
        consume = 2'd3;
        @(negedge clk); consume = 2'd0;
        chk("oc_empty", empty, 1'b1);
        chk("oc_v0", valid0, 1'b0);

        // streaming with consume=3 (treated as 2)
        exp_pc = 32'h120; seen = 0;
        run_mem(24, 2'd3, 1'b1);
`ifdef IFQ_BYPASS_EN
        chk("seq_seen", 32'(seen), 32'd12);
`else
        chk("seq_seen", 32'(seen), 32'd11);
`endif

        // reset asserted mid-transaction
        mem_if.mem_gnt = mem_if.mem_req;
        @(negedge clk); mem_if.mem_gnt = 1'b0;
        n_rst = 1'b0;
        #1;
        chk("rst2_req", mem_if.mem_req, 1'b0);
        chk("rst2_addr", mem_if.mem_addr, 32'h0);
        chk("rst2_empty", empty, 1'b1);
        chk("rst2_v0", valid0, 1'b0);
        @(negedge clk); n_rst = 1'b1;
        @(negedge clk);
        chk("rst2_rereq", mem_if.mem_req, 1'b1);
        chk("rst2_readdr", mem_if.mem_addr, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
